history_reader: RTL and testbench
=================================

HISTORY_READER -- requirements
Module: history_reader

Interface
REQ-001 SHALL have parameter TCQ, default 100, the clock-to-out delay in ps on every registered assignment.
REQ-002 SHALL have port lnk_clk, input, 1 bit: link clock; the block's single clock, all logic on its rising edge.
REQ-003 SHALL have port lnk_reset, input, 1 bit: reset; asynchronous, active-high.
REQ-004 SHALL have port dump_start, input, 1 bit: one-cycle request to begin a dump.
REQ-005 SHALL have port dump_addr, input, [0:8]: first history address to read; sampled on an accepted dump_start.
REQ-006 SHALL have port dump_count, input, [0:9]: number of entries to read, 1..512; sampled on an accepted dump_start.
REQ-007 SHALL have port dump_abort, input, 1 bit: terminates an active dump.
REQ-008 SHALL have port hist_rd_en, output, 1 bit: read enable into the history BRAM read port.
REQ-009 SHALL have port hist_rd_addr, output, [0:8]: read address into the history BRAM read port.
REQ-010 SHALL have port hist_dout, input, [0:35]: history BRAM read data, valid exactly one cycle after hist_rd_en.
REQ-011 SHALL have port out_data, output, [0:35]: history entry presented to the consumer.
REQ-012 SHALL have port out_addr, output, [0:8]: history address of out_data.
REQ-013 SHALL have port out_valid, output, 1 bit: out_data, out_addr and out_last are valid.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer accepts the current entry.
REQ-015 SHALL have port out_last, output, 1 bit: the current entry is the final entry of the dump.
REQ-016 SHALL have port dump_busy, output, 1 bit: a dump is in progress.
REQ-017 SHALL have port dump_done, output, 1 bit: one-cycle pulse when a dump completes or aborts.

Function
REQ-018 SHALL implement states IDLE, RUN and DRAIN.
- IDLE -> RUN on dump_start with dump_count != 0.
- RUN -> DRAIN when the final read has been issued.
- DRAIN -> IDLE when the final entry has been accepted; dump_done pulses in that cycle.
REQ-019 SHALL ignore dump_start while not IDLE.
REQ-020 SHALL treat dump_start with dump_count == 0 as a null dump: stay IDLE, pulse dump_done in the next cycle, produce no reads.
REQ-021 SHALL hold dump_busy high in RUN and DRAIN, low in IDLE.
REQ-022 SHALL assert hist_rd_en for exactly one cycle per issued read, and only in RUN; each read is at most one cycle so generator writes are blocked only for that cycle.
REQ-023 SHALL issue reads at sequential addresses starting at dump_addr, wrapping 511 -> 0.
REQ-024 SHALL capture hist_dout one cycle after each read into a 2-entry output FIFO tagged with {address, last}.
REQ-025 SHALL issue a read only when FIFO occupancy plus in-flight reads < 2, so no entry is ever dropped.
REQ-026 SHALL sustain one entry per cycle while out_ready is held high; first out_valid occurs 2 cycles after the accepted dump_start.
REQ-027 SHALL treat an entry as transferred when out_valid && out_ready; out_data, out_addr and out_last SHALL stay stable while out_valid && !out_ready.
REQ-028 SHALL assert out_last only on entry number dump_count.
REQ-029 SHALL keep the remaining-count counter 10 bits wide, decrementing on each read issue.
REQ-030 SHALL, on dump_abort in RUN or DRAIN:
- stop issuing reads;
- flush the FIFO;
- discard any in-flight read data;
- deassert out_valid next cycle;
- pulse dump_done next cycle;
- return to IDLE.
REQ-031 SHALL ignore dump_abort in IDLE; dump_abort takes priority over a same-cycle out_ready transfer, which is discarded.

Reset
REQ-032 SHALL, on lnk_reset asserted (asynchronous), immediately force:
- state = IDLE;
- FIFO empty, in-flight flag clear;
- hist_rd_en = 0, hist_rd_addr = 0;
- out_valid = 0, out_last = 0, out_data = 0, out_addr = 0;
- dump_busy = 0, dump_done = 0.
REQ-033 SHALL discard a mid-dump reset without any dump_done pulse; the first dump after deassertion SHALL behave identically to a post-power-up dump.

Structure
REQ-034 SHALL place these in a shared package:
- history address width 9 and entry width 36;
- region bases IREQ = 0 and IRESP = 256;
- state encodings.
REQ-035 SHALL implement the 2-entry output FIFO as one sub-module, history_rd_fifo; all other logic stays in history_reader.

Verification
REQ-036 Bench SHALL run: start addr 0x000, count 4, out_ready=1 -> reads at 0..3 on consecutive cycles; out_valid 2 cycles after start; out_last on addr 3; dump_done once.
REQ-037 Bench SHALL run: start addr 0x1FE, count 4 -> out_addr sequence 0x1FE, 0x1FF, 0x000, 0x001.
REQ-038 Bench SHALL run: count 8 with out_ready toggling 1/0 -> all 8 entries exactly once, in order, data matching the preloaded BRAM; FIFO never overflows; data stable while stalled.
REQ-039 Bench SHALL run: dump_abort after 3 transfers of a 10-entry dump -> no further hist_rd_en; out_valid low next cycle; single dump_done; dump_start accepted immediately after.
REQ-040 Bench SHALL run: count 0 -> no hist_rd_en; dump_done one cycle later; dump_start during busy ignored.
REQ-041 Bench SHALL run: lnk_reset asserted mid-dump -> all outputs 0 without a clock edge; no dump_done; a following 2-entry dump is correct.

Source files
------------

// File: rtl/history_reader_pkg.sv
// Shared widths, region bases, FSM encoding and the FIFO entry type for the
// history dump reader.
package history_reader_pkg;

    localparam int HIST_ADDR_W = 9;
    localparam int HIST_DATA_W = 36;
    localparam int CNT_W       = 10;

    localparam logic [0:HIST_ADDR_W-1] IREQ_BASE  = 9'd0;
    localparam logic [0:HIST_ADDR_W-1] IRESP_BASE = 9'd256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [0:HIST_DATA_W-1] data;
        logic [0:HIST_ADDR_W-1] addr;
        logic                   last;
    } hist_entry_t;

endpackage

// File: rtl/history_rd_fifo.sv
// Two-entry output FIFO holding BRAM read data tagged with its address and
// last flag; the head stays put until popped.
module history_rd_fifo
    import history_reader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  hist_entry_t push_entry,
    input  logic        pop,
    output hist_entry_t head,
    output logic [1:0]  count
);

    hist_entry_t mem [2];
    logic        wr_ptr;
    logic        rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/history_reader.sv
// Reads dump_count consecutive history BRAM entries from dump_addr (wrapping)
// and presents them on a ready/valid stream, with abort and null-dump support.
module history_reader
    import history_reader_pkg::*;
#(
    parameter int TCQ = 100
) (
    input  logic                   lnk_clk,
    input  logic                   lnk_reset,
    input  logic                   dump_start,
    input  logic [0:HIST_ADDR_W-1] dump_addr,
    input  logic [0:CNT_W-1]       dump_count,
    input  logic                   dump_abort,
    output logic                   hist_rd_en,
    output logic [0:HIST_ADDR_W-1] hist_rd_addr,
    input  logic [0:HIST_DATA_W-1] hist_dout,
    output logic [0:HIST_DATA_W-1] out_data,
    output logic [0:HIST_ADDR_W-1] out_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   dump_busy,
    output logic                   dump_done
);

    state_t                 state;
    logic [0:HIST_ADDR_W-1] rd_addr;
    logic [0:CNT_W-1]       remaining;
    logic                   vld_p1;
    logic [0:HIST_ADDR_W-1] addr_p1;
    logic                   last_p1;
    logic [1:0]             fifo_count;
    hist_entry_t            head;
    hist_entry_t            push_entry;
    logic                   abort;
    logic                   pop;
    logic                   issue;
    logic [2:0]             credit;

    assign abort  = dump_abort && (state != ST_IDLE);
    assign pop    = out_valid && out_ready && !abort;
    assign credit = {1'b0, fifo_count} + {2'b00, vld_p1};
    // A same-cycle pop frees a slot, which is what lets the reader keep up at full rate.
    assign issue  = (state == ST_RUN) && !abort &&
                    ((credit < 3'd2) || ((credit == 3'd2) && pop));

    assign hist_rd_en   = issue;
    assign hist_rd_addr = rd_addr;
    assign dump_busy    = (state != ST_IDLE);

    always_ff @(posedge lnk_clk or posedge lnk_reset) begin
        if (lnk_reset) begin
            state     <= ST_IDLE;
            rd_addr   <= '0;
            remaining <= '0;
            vld_p1    <= 1'b0;
            dump_done <= 1'b0;
        end else begin
            dump_done <= 1'b0;
            vld_p1    <= issue;
            case (state)
                ST_IDLE: begin
                    if (dump_start) begin
                        if (dump_count == '0) begin
                            dump_done <= 1'b1;
                        end else begin
                            state     <= ST_RUN;
                            rd_addr   <= dump_addr;
                            remaining <= dump_count;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        dump_done <= 1'b1;
                    end else if (issue) begin
                        rd_addr   <= rd_addr + 9'd1;
                        remaining <= remaining - 10'd1;
                        if (remaining == 10'd1) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort || (pop && head.last)) begin
                        state     <= ST_IDLE;
                        dump_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stage p1: tag of the read whose data is on hist_dout this cycle
    always_ff @(posedge lnk_clk) begin
        if (issue) begin
            addr_p1 <= rd_addr;
            last_p1 <= (remaining == 10'd1);
        end
    end

    assign push_entry = '{data: hist_dout, addr: addr_p1, last: last_p1};

    history_rd_fifo u_fifo (
        .clk        (lnk_clk),
        .rst        (lnk_reset),
        .flush      (abort),
        .push       (vld_p1 && !abort),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count)
    );

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = head.data;
    assign out_addr  = head.addr;
    assign out_last  = head.last;

endmodule

// File: tb/tb_history_reader.sv
// Scoreboard bench for history_reader: stimulus pushes expected entries, a
// negedge monitor pops and compares on every accepted transfer.
module tb_history_reader;

    logic        lnk_clk;
    logic        lnk_reset;
    logic        dump_start;
    logic [0:8]  dump_addr;
    logic [0:9]  dump_count;
    logic        dump_abort;
    logic        hist_rd_en;
    logic [0:8]  hist_rd_addr;
    logic [0:35] hist_dout;
    logic [0:35] out_data;
    logic [0:8]  out_addr;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        dump_busy;
    logic        dump_done;

    typedef struct packed {
        logic [0:8]  addr;
        logic [0:35] data;
        logic        last;
    } exp_t;

    exp_t        sb [$];
    logic [0:35] bram [512];
    int          checks = 0;
    int          failures = 0;
    int          rd_cnt = 0;
    int          done_cnt = 0;
    int          xfer_cnt = 0;
    int          done_base = 0;
    logic [0:8]  exp_rd = '0;

    history_reader dut (
        .lnk_clk      (lnk_clk),
        .lnk_reset    (lnk_reset),
        .dump_start   (dump_start),
        .dump_addr    (dump_addr),
        .dump_count   (dump_count),
        .dump_abort   (dump_abort),
        .hist_rd_en   (hist_rd_en),
        .hist_rd_addr (hist_rd_addr),
        .hist_dout    (hist_dout),
        .out_data     (out_data),
        .out_addr     (out_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .dump_busy    (dump_busy),
        .dump_done    (dump_done)
    );

    function automatic logic [0:35] bram_val(input logic [0:8] a);
        logic [35:0] v;
        v = {4'hA, a, ~a, 14'h2C5F};
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        lnk_clk = 1'b0;
        forever #5 lnk_clk = ~lnk_clk;
    end

    initial begin
        for (int i = 0; i < 512; i++) bram[i] = bram_val(9'(i));
    end

    always @(posedge lnk_clk) begin
        if (hist_rd_en) hist_dout <= bram[hist_rd_addr];
    end

    // Monitor: samples one time unit after each falling edge
    logic        stalled_prev = 1'b0;
    logic [0:8]  held_addr;
    logic [0:35] held_data;
    logic        held_last;
    exp_t        e;

    always @(negedge lnk_clk) begin
        #1;
        if (lnk_reset) begin
            stalled_prev = 1'b0;
        end else begin
            if (hist_rd_en) begin
                rd_cnt++;
                check("rd_addr_seq", 64'(hist_rd_addr), 64'(exp_rd));
                check("rd_only_busy", 64'(dump_busy), 64'd1);
                exp_rd = exp_rd + 9'd1;
            end
            if (dump_done) done_cnt++;
            if (stalled_prev && out_valid) begin
                check("stall_addr", 64'(out_addr), 64'(held_addr));
                check("stall_data", 64'(out_data), 64'(held_data));
                check("stall_last", 64'(out_last), 64'(held_last));
            end
            if (out_valid && out_ready && !dump_abort) begin
                xfer_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected actual=addr %0h required=no entry", out_addr);
                end else begin
                    e = sb.pop_front();
                    check("out_addr", 64'(out_addr), 64'(e.addr));
                    check("out_data", 64'(out_data), 64'(e.data));
                    check("out_last", 64'(out_last), 64'(e.last));
                end
            end
            stalled_prev = out_valid && !out_ready && !dump_abort;
            held_addr = out_addr;
            held_data = out_data;
            held_last = out_last;
        end
    end

    task automatic issue_start(input logic [0:8] a, input logic [0:9] c, input bit do_push);
        logic [0:8] ad;
        dump_start = 1'b1;
        dump_addr  = a;
        dump_count = c;
        exp_rd     = a;
        done_base  = done_cnt;
        if (do_push) begin
            for (int i = 0; i < int'(c); i++) begin
                ad = a + 9'(i);
                sb.push_back('{addr: ad, data: bram_val(ad), last: (i == int'(c) - 1)});
            end
        end
    endtask

    task automatic start_dump(input logic [0:8] a, input logic [0:9] c, input bit do_push);
        @(negedge lnk_clk);
        issue_start(a, c, do_push);
        @(negedge lnk_clk);
        dump_start = 1'b0;
    endtask

    task automatic wait_done(input bit toggle);
        for (int n = 0; n < 300 && done_cnt == done_base; n++) begin
            @(negedge lnk_clk);
            if (toggle) out_ready = ~out_ready;
            #2;
        end
        @(negedge lnk_clk);
        out_ready = 1'b1;
        #2;
        repeat (3) begin
            @(negedge lnk_clk);
            #2;
        end
        check("done_once", 64'(done_cnt - done_base), 64'd1);
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        lnk_reset  = 1'b0;
        dump_start = 1'b0;
        dump_addr  = '0;
        dump_count = '0;
        dump_abort = 1'b0;
        out_ready  = 1'b1;
        #2 lnk_reset = 1'b1;
        #1;
        check("rst_rd_en", 64'(hist_rd_en), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(dump_busy), 64'd0);
        check("rst_done", 64'(dump_done), 64'd0);
        repeat (2) @(negedge lnk_clk);
        lnk_reset = 1'b0;

        // Basic 4-entry dump from 0 with exact read/valid timing
        start_dump(9'h000, 10'd4, 1'b1);
        #2;
        check("t1_valid_c1", 64'(out_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge lnk_clk);
                #2;
            end
            check("t1_rd_en", 64'(hist_rd_en), 64'd1);
            check("t1_rd_addr", 64'(hist_rd_addr), 64'(i));
            if (i == 1) check("t1_valid_c2", 64'(out_valid), 64'd0);
            if (i == 2) begin
                check("t1_valid_c3", 64'(out_valid), 64'd1);
                check("t1_first_addr", 64'(out_addr), 64'h000);
            end
        end
        @(negedge lnk_clk);
        #2;
        check("t1_rd_stop", 64'(hist_rd_en), 64'd0);
        wait_done(1'b0);

        // Wrap-around 0x1FE..0x001, expected sequence written out by hand
        sb.push_back('{addr: 9'h1FE, data: bram_val(9'h1FE), last: 1'b0});
        sb.push_back('{addr: 9'h1FF, data: bram_val(9'h1FF), last: 1'b0});
        sb.push_back('{addr: 9'h000, data: bram_val(9'h000), last: 1'b0});
        sb.push_back('{addr: 9'h001, data: bram_val(9'h001), last: 1'b1});
        start_dump(9'h1FE, 10'd4, 1'b0);
        wait_done(1'b0);

        // Backpressure: out_ready toggles every cycle
        start_dump(9'h040, 10'd8, 1'b1);
        wait_done(1'b1);

        // Abort after three transfers, then an immediate new dump
        base = xfer_cnt;
        start_dump(9'h0A0, 10'd10, 1'b1);
        for (int n = 0; n < 100 && xfer_cnt < base + 3; n++) begin
            @(negedge lnk_clk);
            #2;
        end
        check("t4_three_xfers", 64'(xfer_cnt - base), 64'd3);
        @(negedge lnk_clk);
        dump_abort = 1'b1;
        sb.delete();
        #2;
        base = rd_cnt;
        @(negedge lnk_clk);
        dump_abort = 1'b0;
        check("t4_abort_done_base", 64'(done_cnt - done_base), 64'd0);
        issue_start(9'h150, 10'd2, 1'b1);
        #2;
        check("t4_valid_low", 64'(out_valid), 64'd0);
        check("t4_done_pulse", 64'(dump_done), 64'd1);
        check("t4_no_read", 64'(rd_cnt - base), 64'd0);
        check("t4_abort_done_once", 64'(done_cnt - done_base), 64'd1);
        done_base = done_cnt;
        @(negedge lnk_clk);
        dump_start = 1'b0;
        wait_done(1'b0);

        // Null dump
        base = rd_cnt;
        start_dump(9'h033, 10'd0, 1'b0);
        #2;
        check("t5_null_done", 64'(dump_done), 64'd1);
        check("t5_null_rd_en", 64'(hist_rd_en), 64'd0);
        check("t5_null_busy", 64'(dump_busy), 64'd0);
        repeat (3) begin
            @(negedge lnk_clk);
            #2;
        end
        check("t5_null_no_reads", 64'(rd_cnt - base), 64'd0);
        check("t5_null_done_once", 64'(done_cnt - done_base), 64'd1);

        // dump_start while busy is ignored (consumer stalled meanwhile)
        out_ready = 1'b0;
        start_dump(9'h100, 10'd4, 1'b1);
        @(negedge lnk_clk);
        dump_start = 1'b1;
        dump_addr  = 9'h080;
        dump_count = 10'd3;
        @(negedge lnk_clk);
        dump_start = 1'b0;
        repeat (3) @(negedge lnk_clk);
        out_ready = 1'b1;
        wait_done(1'b0);

        // Reset in the middle of a dump
        start_dump(9'h020, 10'd10, 1'b1);
        repeat (3) @(negedge lnk_clk);
        lnk_reset = 1'b1;
        #2;
        check("t6_rd_en", 64'(hist_rd_en), 64'd0);
        check("t6_rd_addr", 64'(hist_rd_addr), 64'd0);
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_out_last", 64'(out_last), 64'd0);
        check("t6_out_data", 64'(out_data), 64'd0);
        check("t6_out_addr", 64'(out_addr), 64'd0);
        check("t6_busy", 64'(dump_busy), 64'd0);
        check("t6_done", 64'(dump_done), 64'd0);
        sb.delete();
        done_base = done_cnt;
        repeat (2) @(negedge lnk_clk);
        lnk_reset = 1'b0;
        repeat (3) @(negedge lnk_clk);
        #2;
        check("t6_no_done", 64'(done_cnt - done_base), 64'd0);
        start_dump(9'h1FF, 10'd2, 1'b1);
        wait_done(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
